// File: rtl/torus_route_unit.sv
// torus_route_unit: single-stage route-compute register for a 3D torus router.
// Picks the output port for each packet from its head flit using dimension-order
// routing (optionally credit-adaptive between X and Y). The port is latched for
// the body and tail flits. The VC class bit is updated on link wrap.
// Optional feature: define RC_PRIO_DEC_EN to decrement the head CMP field by one
// on HEAD/SINGLE flits, saturating at 0.
module torus_route_unit #(
    parameter int unsigned CUR_X     = 0,
    parameter int unsigned CUR_Y     = 0,
    parameter int unsigned CUR_Z     = 0,
    parameter int unsigned XSIZE     = 4,
    parameter int unsigned YSIZE     = 4,
    parameter int unsigned ZSIZE     = 4,
    parameter int unsigned FLIT_SIZE = 64,
    parameter int unsigned DST_XPOS  = 59,
    parameter int unsigned DST_YPOS  = 55,
    parameter int unsigned DST_ZPOS  = 51,
    parameter int unsigned CMP_POS   = 47,
    parameter int unsigned CMP_LEN   = 8,
    parameter int unsigned ADAPTIVE  = 0,
    parameter int unsigned CW        = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [FLIT_SIZE-1:0] in_flit,
    input  logic [2:0]           in_dir,
    input  logic [6*CW-1:0]      credits,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [FLIT_SIZE-1:0] out_flit,
    output logic [2:0]           out_dir,
    output logic                 out_eject,
    output logic                 err
);

    localparam int unsigned XW = $clog2(XSIZE);
    localparam int unsigned YW = $clog2(YSIZE);
    localparam int unsigned ZW = $clog2(ZSIZE);

    localparam logic [2:0] D_XPOS  = 3'd0;
    localparam logic [2:0] D_YPOS  = 3'd1;
    localparam logic [2:0] D_ZPOS  = 3'd2;
    localparam logic [2:0] D_XNEG  = 3'd3;
    localparam logic [2:0] D_YNEG  = 3'd4;
    localparam logic [2:0] D_ZNEG  = 3'd5;
    localparam logic [2:0] D_EJECT = 3'd6;

    localparam logic [1:0] T_BODY   = 2'b00;
    localparam logic [1:0] T_HEAD   = 2'b01;
    localparam logic [1:0] T_TAIL   = 2'b10;
    localparam logic [1:0] T_SINGLE = 2'b11;

    localparam logic [1:0] R_DONE = 2'd0;
    localparam logic [1:0] R_POS  = 2'd1;
    localparam logic [1:0] R_NEG  = 2'd2;

    typedef enum logic {IDLE, IN_PKT} state_t;

    state_t               state;
    logic [2:0]           lat_dir;
    logic [1:0]           ftype;
    logic [XW-1:0]        dx;
    logic [YW-1:0]        dy;
    logic [ZW-1:0]        dz;
    logic [1:0]           xr;
    logic [1:0]           yr;
    logic [1:0]           zr;
    logic [CW-1:0]        cred_x;
    logic [CW-1:0]        cred_y;
    logic [2:0]           route;
    logic                 same_dim;
    logic [FLIT_SIZE-1:0] head_flit;
`ifdef RC_PRIO_DEC_EN
    logic [CMP_LEN-1:0]   cmp;
`endif
    logic                 unused_credits;

    // Per-dimension decision: done, positive or negative; exact half ties to positive.
    function automatic logic [1:0] dim_route(input int unsigned dst, input int unsigned cur,
                                             input int unsigned size);
        int unsigned off;
        off = (dst + size - cur) % size;
        if (off == 0) return R_DONE;
        if ((off << 1) <= size) return R_POS;
        return R_NEG;
    endfunction

    // Dimension index of a link direction (0 X, 1 Y, 2 Z, 3 none).
    function automatic int unsigned dim_of(input logic [2:0] d);
        if (d >= 3'd6) return 3;
        if (d >= 3'd3) return 32'(d - 3'd3);
        return 32'(d);
    endfunction

    // True when leaving this node on direction d crosses the torus wrap-around link.
    function automatic logic wraps(input logic [2:0] d);
        case (d)
            D_XPOS:  return CUR_X == XSIZE - 1;
            D_XNEG:  return CUR_X == 0;
            D_YPOS:  return CUR_Y == YSIZE - 1;
            D_YNEG:  return CUR_Y == 0;
            D_ZPOS:  return CUR_Z == ZSIZE - 1;
            D_ZNEG:  return CUR_Z == 0;
            default: return 1'b0;
        endcase
    endfunction

    assign in_ready       = ~out_valid | out_ready;
    assign ftype          = in_flit[FLIT_SIZE-1 -: 2];
    assign unused_credits = ^{credits[2*CW +: CW], credits[4*CW +: 2*CW]};

    // Route computation and head flit rewrite for the flit currently on the input.
    always_comb begin
        dx        = in_flit[DST_XPOS -: XW];
        dy        = in_flit[DST_YPOS -: YW];
        dz        = in_flit[DST_ZPOS -: ZW];
        xr        = dim_route(32'(dx), CUR_X, XSIZE);
        yr        = dim_route(32'(dy), CUR_Y, YSIZE);
        zr        = dim_route(32'(dz), CUR_Z, ZSIZE);
        cred_x    = (xr == R_NEG) ? credits[3*CW +: CW] : credits[0 +: CW];
        cred_y    = credits[CW +: CW];
        route     = D_EJECT;
        if (zr != R_DONE) route = (zr == R_POS) ? D_ZPOS : D_ZNEG;
        if (yr != R_DONE) route = (yr == R_POS) ? D_YPOS : D_YNEG;
        if (xr != R_DONE) route = (xr == R_POS) ? D_XPOS : D_XNEG;
        if ((ADAPTIVE != 0) && (xr != R_DONE) && (yr == R_POS) && (cred_y > cred_x))
            route = D_YPOS;
        same_dim  = (in_dir < 3'd6) && (dim_of(route) == dim_of(in_dir));
        head_flit = in_flit;
        if (!same_dim)
            head_flit[FLIT_SIZE-3] = 1'b0;
        else if (wraps(route))
            head_flit[FLIT_SIZE-3] = 1'b1;
`ifdef RC_PRIO_DEC_EN
        cmp = in_flit[CMP_POS -: CMP_LEN];
        head_flit[CMP_POS -: CMP_LEN] = (cmp == '0) ? '0 : cmp - CMP_LEN'(1);
`endif
    end

    // Packet FSM, direction latch, output register and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lat_dir   <= D_XPOS;
            out_valid <= 1'b0;
            out_flit  <= '0;
            out_dir   <= 3'd0;
            out_eject <= 1'b0;
            err       <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            case (ftype)
                T_HEAD, T_SINGLE: begin
                    out_flit  <= head_flit;
                    out_dir   <= route;
                    out_eject <= (route == D_EJECT);
                    if (ftype == T_HEAD) begin
                        lat_dir <= route;
                        state   <= IN_PKT;
                        if (state == IN_PKT) err <= 1'b1;
                    end
                end
                T_BODY, T_TAIL: begin
                    out_flit <= in_flit;
                    if (state == IDLE) begin
                        out_dir   <= D_EJECT;
                        out_eject <= 1'b1;
                        err       <= 1'b1;
                    end else begin
                        out_dir   <= lat_dir;
                        out_eject <= (lat_dir == D_EJECT);
                        if (ftype == T_TAIL) state <= IDLE;
                    end
                end
                default: begin
                    out_flit <= in_flit;
                end
            endcase
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
